// File: rtl/pet_fsm_param.sv
// pet_fsm_param: parametrised virtual-pet controller with saturating needs, menu cursor, sleep and death.
module pet_fsm_param #(
    parameter int          NUM_NEEDS     = 5,
    parameter int          LVL_W         = 3,
    parameter int          LVL_MAX       = 7,
    parameter int          LVL_INIT      = 5,
    parameter int          DEATH_SUM     = 5,
    parameter logic [33:0] BASE_INTERVAL = 34'h0FFFFFFFF,
    parameter int          SLEEP_TICKS   = 4,
    parameter int          IDX_FEED      = 1,
    parameter int          IDX_SLEEP     = 2,
    parameter int          IDX_PLAY      = 3,
    parameter int          IDX_HEALTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_next,
    input  logic                         btn_act,
    input  logic                         btn_prev,
    input  logic                         test,
    input  logic [2:0]                   color,
    input  logic [1:0]                   time_control,
    input  logic                         luz_n,
    output logic [1:0]                   state_out,
    output logic [$clog2(NUM_NEEDS)-1:0] sel_out,
    output logic [LVL_W-1:0]             level_out,
    output logic [NUM_NEEDS*LVL_W-1:0]   levels_flat,
    output logic                         dead
);
    localparam int SEL_W = $clog2(NUM_NEEDS);
    localparam int SUM_W = $clog2(NUM_NEEDS*LVL_MAX+1);
    localparam int SLP_W = $clog2(SLEEP_TICKS+1);
    localparam logic [LVL_W-1:0] MAX     = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] INI     = LVL_W'(LVL_INIT);
    localparam logic [LVL_W-1:0] ONE     = LVL_W'(1);
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(NUM_NEEDS-1);
    localparam logic [SEL_W-1:0] S_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] S_FEED  = SEL_W'(IDX_FEED);
    localparam logic [SEL_W-1:0] S_SLEEP = SEL_W'(IDX_SLEEP);
    localparam logic [SEL_W-1:0] S_PLAY  = SEL_W'(IDX_PLAY);
    localparam logic [SLP_W-1:0] SLP_ONE = SLP_W'(1);
    localparam logic [SLP_W-1:0] SLP_END = SLP_W'(SLEEP_TICKS-1);

    typedef enum logic [1:0] {INIT, MENU, SLEEP, DEAD} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [LVL_W-1:0]   lvl_q [NUM_NEEDS];
    logic [LVL_W-1:0]   lvl_d [NUM_NEEDS];
    logic [LVL_W-1:0]   dec_l [NUM_NEEDS];
    logic [33:0]        cnt_q, cnt_d, interval;
    logic [2:0]         exp_q, exp_d;
    logic [SLP_W-1:0]   slp_q, slp_d;
    logic [SUM_W-1:0]   sum;
    logic               tick, any_btn;

    function automatic logic [LVL_W-1:0] inc(input logic [LVL_W-1:0] v);
        return (v >= MAX) ? v : v + ONE;
    endfunction

    function automatic logic [LVL_W-1:0] dec(input logic [LVL_W-1:0] v);
        return (v == '0) ? v : v - ONE;
    endfunction

    always_comb begin
        interval = BASE_INTERVAL >> time_control;
        tick     = cnt_q == interval;
        cnt_d    = tick ? '0 : cnt_q + 34'd1;
        any_btn  = btn_next | btn_act | btn_prev;
        sum      = '0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            sum      = sum + SUM_W'(lvl_q[i]);
            dec_l[i] = (tick && !test) ? dec(lvl_q[i]) : lvl_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lvl_d   = lvl_q;
        exp_d   = exp_q;
        slp_d   = slp_q;
        case (state_q)
            INIT: if (any_btn) begin
                state_d = MENU;
                sel_d   = '0;
            end
            MENU: if (!test && 32'(sum) < DEATH_SUM) state_d = DEAD;
            else begin
                // act adjustments build on the already-decayed levels
                lvl_d = dec_l;
                if (btn_next) sel_d = (sel_q == LAST) ? '0 : sel_q + S_ONE;
                else if (btn_prev) sel_d = (sel_q == '0) ? LAST : sel_q - S_ONE;
                else if (btn_act) begin
                    if (test) lvl_d[sel_q] = inc(dec_l[sel_q]);
                    else if (sel_q == S_FEED) begin
                        if (dec_l[IDX_FEED] != '0 && dec_l[IDX_FEED] < MAX) begin
                            exp_d = (exp_q == 3'd5) ? 3'd0 : exp_q + 3'd1;
                            if (color == exp_q) lvl_d[IDX_FEED] = inc(dec_l[IDX_FEED]);
                            else begin
                                lvl_d[IDX_FEED]   = dec(dec_l[IDX_FEED]);
                                lvl_d[IDX_HEALTH] = dec(dec_l[IDX_HEALTH]);
                            end
                        end
                    end else if (sel_q == S_SLEEP) begin
                        if (luz_n) begin
                            state_d = SLEEP;
                            slp_d   = '0;
                        end
                    end else if (sel_q == S_PLAY) begin
                        if (dec_l[IDX_PLAY] < MAX) begin
                            lvl_d[IDX_PLAY] = inc(dec_l[IDX_PLAY]);
                            if (dec_l[IDX_FEED] != '0 && dec_l[IDX_SLEEP] != '0) begin
                                lvl_d[IDX_FEED]  = dec(dec_l[IDX_FEED]);
                                lvl_d[IDX_SLEEP] = dec(dec_l[IDX_SLEEP]);
                            end
                        end
                    end else lvl_d[sel_q] = inc(dec_l[sel_q]);
                end
            end
            SLEEP: if (btn_next || btn_prev || !luz_n || lvl_q[IDX_SLEEP] == MAX) state_d = MENU;
            else if (tick) begin
                slp_d = (slp_q == SLP_END) ? '0 : slp_q + SLP_ONE;
                if (slp_q == SLP_END) begin
                    lvl_d[IDX_SLEEP]  = MAX;
                    lvl_d[IDX_HEALTH] = inc(lvl_q[IDX_HEALTH]);
                    state_d           = MENU;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            sel_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            slp_q   <= '0;
            for (int i = 0; i < NUM_NEEDS; i++) lvl_q[i] <= INI;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            slp_q   <= slp_d;
            lvl_q   <= lvl_d;
        end
    end

    always_comb begin
        levels_flat = '0;
        for (int i = 0; i < NUM_NEEDS; i++) levels_flat[i*LVL_W +: LVL_W] = lvl_q[i];
    end

    assign state_out = state_q;
    assign sel_out   = sel_q;
    assign level_out = (state_q == INIT || state_q == DEAD) ? '0 : lvl_q[sel_q];
    assign dead      = state_q == DEAD;
endmodule

// File: tb/tb_pet_fsm_param.sv
// tb_pet_fsm_param: directed scoreboard bench for pet_fsm_param with a fast prescaler.
module tb_pet_fsm_param;
    logic        clk = 1'b0;
    logic        reset, btn_next, btn_act, btn_prev, test, luz_n;
    logic [2:0]  color;
    logic [1:0]  time_control;
    logic [1:0]  state_out;
    logic [2:0]  sel_out;
    logic [2:0]  level_out;
    logic [14:0] levels_flat;
    logic        dead;

    typedef struct packed {
        logic [1:0]  st;
        logic [2:0]  sel;
        logic [14:0] flat;
        logic [2:0]  lvl;
        logic        dead;
    } exp_t;

    exp_t  exp_fifo [$];
    string name_fifo [$];
    int    checks = 0;
    int    errors = 0;

    pet_fsm_param #(.BASE_INTERVAL(34'd7)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_act(btn_act), .btn_prev(btn_prev),
        .test(test), .color(color), .time_control(time_control), .luz_n(luz_n),
        .state_out(state_out), .sel_out(sel_out), .level_out(level_out),
        .levels_flat(levels_flat), .dead(dead)
    );

    always #5 clk = ~clk;

    // monitor: compares the oldest expectation against the outputs mid-cycle
    always @(negedge clk) begin
        if (exp_fifo.size() != 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_fifo.pop_front();
            n = name_fifo.pop_front();
            a = {state_out, sel_out, levels_flat, level_out, dead};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d sel=%0d lv=%h out=%0d dead=%0b, want st=%0d sel=%0d lv=%h out=%0d dead=%0b",
                         n, a.st, a.sel, a.flat, a.lvl, a.dead, e.st, e.sel, e.flat, e.lvl, e.dead);
            end
        end
    end

    function automatic logic [14:0] lv(input int a0, input int a1, input int a2, input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic chk(input string nm, input int st, input int sel, input logic [14:0] f);
        exp_t e;
        e.st   = 2'(st);
        e.sel  = 3'(sel);
        e.flat = f;
        e.lvl  = (st == 0 || st == 3) ? 3'd0 : f[sel*3 +: 3];
        e.dead = (st == 3);
        exp_fifo.push_back(e);
        name_fifo.push_back(nm);
    endtask

    task automatic step(input int m);
        repeat (m) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic nx, input logic ac, input logic pv);
        btn_next = nx;
        btn_act  = ac;
        btn_prev = pv;
        step(1);
        btn_next = 1'b0;
        btn_act  = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        btn_next = 1'b0;
        btn_act  = 1'b0;
        btn_prev = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] all5, all4, all1, all0;
        all5 = lv(5, 5, 5, 5, 5);
        all4 = lv(4, 4, 4, 4, 4);
        all1 = lv(1, 1, 1, 1, 1);
        all0 = lv(0, 0, 0, 0, 0);
        test = 1'b0; color = 3'd0; time_control = 2'd0; luz_n = 1'b0;
        // navigation and first decay tick (ticks land on edge 8, 16, ... after reset)
        do_reset();                chk("reset", 0, 0, all5);
        press(0, 1, 0);            chk("init_to_menu", 1, 0, all5);
        step(6);                   chk("pre_tick", 1, 0, all5);
        step(1);                   chk("first_tick", 1, 0, all4);
        press(0, 0, 1);            chk("prev_wrap", 1, 4, all4);
        press(1, 0, 0);            chk("next_wrap", 1, 0, all4);
        press(1, 0, 1);            chk("next_prio", 1, 1, all4);
        // act on health in the same cycle as a tick
        do_reset();
        press(0, 1, 0);
        press(0, 0, 1);
        step(5);
        press(0, 1, 0);            chk("tick_act", 1, 4, lv(4, 4, 4, 4, 5));
        // feeding with expected colour sequence 0,1,2 then play side effects
        do_reset();
        press(0, 1, 0);
        press(1, 0, 0);
        color = 3'd0; press(0, 1, 0); chk("feed_match", 1, 1, lv(5, 6, 5, 5, 5));
        color = 3'd3; press(0, 1, 0); chk("feed_miss", 1, 1, lv(5, 5, 5, 5, 4));
        color = 3'd2; press(0, 1, 0); chk("feed_match2", 1, 1, lv(5, 6, 5, 5, 4));
        press(1, 0, 0);
        press(1, 0, 0);
        step(1);                   chk("decay_sel3", 1, 3, lv(4, 5, 4, 4, 3));
        press(0, 1, 0);            chk("play_side", 1, 3, lv(4, 4, 3, 5, 3));
        // fast decay to death; sum == DEATH_SUM must still be alive
        time_control = 2'd3;
        do_reset();
        press(0, 1, 0);            chk("menu_fast", 1, 0, all5);
        step(4);                   chk("sum_eq", 1, 0, all1);
        step(1);                   chk("sum_zero", 1, 0, all0);
        step(1);                   chk("death", 3, 0, all0);
        press(1, 1, 1);            chk("dead_hold", 3, 0, all0);
        reset = 1'b0; btn_act = 1'b1;
        step(1);                   chk("reset_prio", 0, 0, all5);
        reset = 1'b1; btn_act = 1'b0;
        time_control = 2'd0;
        // full sleep: four ticks then rest=max, health+1
        luz_n = 1'b1;
        do_reset();
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);            chk("sleep_enter", 2, 2, all5);
        step(4);                   chk("sleep_t1", 2, 2, all5);
        step(16);                  chk("sleep_t3", 2, 2, all5);
        step(7);                   chk("sleep_t3b", 2, 2, all5);
        step(1);                   chk("sleep_done", 1, 2, lv(5, 5, 7, 5, 6));
        // early exits: light, then button (cursor stays)
        do_reset();
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        step(5);                   chk("sleep_hold", 2, 2, all5);
        luz_n = 1'b0;
        step(1);                   chk("light_exit", 1, 2, all5);
        luz_n = 1'b1;
        press(0, 1, 0);            chk("sleep_again", 2, 2, all5);
        press(1, 0, 0);            chk("btn_exit", 1, 2, all5);
        // test mode: no decay, plain saturating increments
        luz_n = 1'b0; test = 1'b1;
        do_reset();
        press(0, 1, 0);
        step(160);                 chk("test_nodecay", 1, 0, all5);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);            chk("test_play1", 1, 3, lv(5, 5, 5, 6, 5));
        press(0, 1, 0);
        press(0, 1, 0);            chk("test_play_sat", 1, 3, lv(5, 5, 5, 7, 5));
        press(0, 0, 1);
        press(0, 1, 0);            chk("test_sleep_inc", 1, 2, lv(5, 5, 6, 7, 5));
        step(3);
        if (exp_fifo.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_fifo.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pet_fsm_param.md
Name: pet_fsm_param

Overview:
- Parametrised virtual-pet controller: holds NUM_NEEDS saturating need levels, a menu cursor, a sleep mode and a terminal death state.
- Driven by three debounced single-cycle button pulses, a 3-bit colour sensor code and a light sensor.
- Feeds the display and sprite logic with the current state, the cursor, the selected level and a flat vector of all levels.
- Successor of the fixed 5-need pet FSM: need count, level width, thresholds and sleep length are parameters; one menu state with a cursor replaces one state per need.

Parameters:
- NUM_NEEDS, 5, number of need counters (min 5).
- LVL_W, 3, bit width of each level.
- LVL_MAX, 7, saturation ceiling (must be <= 2^LVL_W-1).
- LVL_INIT, 5, level loaded in INIT.
- DEATH_SUM, 5, pet dies when the sum of all levels < DEATH_SUM.
- BASE_INTERVAL, 34'h0FFFFFFFF, decay prescaler terminal count.
- SLEEP_TICKS, 4, decay ticks needed to complete a sleep.
- IDX_FEED, 1, index of the food need.
- IDX_SLEEP, 2, index of the rest need.
- IDX_PLAY, 3, index of the play need.
- IDX_HEALTH, 4, index of the health need.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-low.
- btn_next, input, 1, one-cycle pulse: cursor forward.
- btn_act, input, 1, one-cycle pulse: act on the selected need.
- btn_prev, input, 1, one-cycle pulse: cursor back.
- test, input, 1, test mode: no decay, no death, no side effects.
- color, input, 3, colour code from the sensor.
- time_control, input, 2, decay speed select.
- luz_n, input, 1, 1 = dark, 0 = light.
- state_out, output, 2, current state (0 INIT, 1 MENU, 2 SLEEP, 3 DEAD).
- sel_out, output, $clog2(NUM_NEEDS), cursor position.
- level_out, output, LVL_W, level at the cursor; 0 in INIT and DEAD.
- levels_flat, output, NUM_NEEDS*LVL_W, all levels; need i occupies bits [i*LVL_W +: LVL_W].
- dead, output, 1, high in DEAD.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=INIT, sel=0, every level=LVL_INIT.
  - Prescaler=0, sleep tick count=0, expected colour=0.
  - All outputs registered; values follow from these registers (dead=0, level_out=0).
- Prescaler:
  - interval = BASE_INTERVAL >> time_control.
  - Counter increments each cycle; when it equals interval it returns to 0 and asserts tick for exactly one cycle.
  - Tick period is interval+1 cycles.
  - The counter runs in every state.
- INIT: any button -> MENU with sel=0. Buttons are otherwise ignored.
- MENU:
  - btn_next: sel+1, wrapping NUM_NEEDS-1 -> 0.
  - btn_prev: sel-1, wrapping 0 -> NUM_NEEDS-1.
  - btn_next has priority over btn_prev and btn_act; only one button is honoured per cycle.
  - Decay: on tick with test=0, every level >0 decrements by 1.
  - Death: when sum(levels) < DEATH_SUM and test=0 -> DEAD on the next edge.
  - The sum is evaluated on registered levels and is ceil(log2(NUM_NEEDS*LVL_MAX+1)) bits wide, with no overflow.
- btn_act in MENU, test=0, depends on sel:
  - IDX_FEED, only when 0 < level < LVL_MAX:
    - color == expected: feed +1.
    - Otherwise: feed -1 and health -1 (health saturates at 0).
    - In both cases expected = (expected==5) ? 0 : expected+1.
  - IDX_SLEEP: if luz_n=1 -> SLEEP, sleep tick count=0. Otherwise no effect.
  - IDX_PLAY: if level < LVL_MAX, play +1; additionally, if feed>0 and rest>0, both -1.
  - Any other index: +1, saturating at LVL_MAX.
- btn_act with test=1: selected level +1 saturating, no side effects. IDX_SLEEP also increments rather than entering sleep.
- Tick and act in the same cycle: decay is applied first, then the act adjustment to the decayed value, each step saturating at 0 and LVL_MAX.
- SLEEP:
  - No decay and no death check.
  - Each tick increments the sleep tick count.
  - When the count reaches SLEEP_TICKS: rest = LVL_MAX, health +1 (saturating), count = 0, -> MENU.
  - Early exit to MENU, levels unchanged: btn_next or btn_prev (sel does not move on that cycle), luz_n=0, or rest already == LVL_MAX.
  - btn_act is ignored.
- DEAD: all inputs ignored and levels frozen until reset; dead=1.
- Reset mid-operation: reset has priority over every event, including tick and button in the same cycle.

Test Plan:
- Parameters BASE_INTERVAL=7, time_control=0. Reset, pulse btn_act -> state_out=1, sel_out=0, all levels 5. First tick 8 cycles later -> all levels 4.
- From MENU, btn_prev at sel=0 -> sel_out=4. btn_next at sel=4 -> sel_out=0. btn_next and btn_prev together -> sel_out increments.
- sel=IDX_FEED, levels 5, expected colour 0: color=0 + btn_act -> feed=6. Then color=3 + btn_act (expected now 1) -> feed=5, health=4.
- test=0, let decay run with time_control=3 (tick every 1 cycle after the prescaler wraps). Once sum<5 -> state_out=3, dead=1. Buttons are then ignored until reset=0.
- luz_n=1, sel=IDX_SLEEP, btn_act -> state_out=2. Levels hold across 3 ticks; 4th tick -> rest=7, health+1, state_out=1. Repeat with luz_n=0 mid-sleep -> immediate MENU, levels unchanged.
- test=1: 20 ticks -> levels unchanged. 3 acts on IDX_PLAY from 5 -> play=7 (saturated), feed and rest untouched.
